// File: rtl/leg_solver_pkg.sv
// Shared types and sizing helpers for leg_solver and its square-root engine.
package leg_solver_pkg;

    typedef enum logic [1:0] {IDLE, MUL, SQRT, DONE} state_t;

    localparam int WIDTH_DEF = 8;
    localparam int PROD_W    = 2 * WIDTH_DEF;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/leg_solver_if.sv
// Operand/result handshake bundle for leg_solver.
// rem_o exists only when LEG_SOLVER_REM_EN is defined.
interface leg_solver_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] hyp_i;
    logic [WIDTH-1:0] leg_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] leg_o;
    logic             err_o;
`ifdef LEG_SOLVER_REM_EN
    logic [2*WIDTH-1:0] rem_o;
`endif

    modport master (
        output in_valid, hyp_i, leg_i, out_ready,
`ifdef LEG_SOLVER_REM_EN
        input  rem_o,
`endif
        input  in_ready, out_valid, leg_o, err_o
    );

    modport slave (
        input  in_valid, hyp_i, leg_i, out_ready,
`ifdef LEG_SOLVER_REM_EN
        output rem_o,
`endif
        output in_ready, out_valid, leg_o, err_o
    );

endinterface

// File: rtl/leg_solver_isqrt_serial.sv
// Bit-serial restoring floor square root, two radicand bits per enabled cycle, MSB first.
// done is high during the final iteration; root/rem are settled after that edge and then hold.
module isqrt_serial
    import leg_solver_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic [2*WIDTH-1:0] radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   root,
    output logic [WIDTH+1:0]   rem
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] rad;
    logic [CW-1:0]      cnt;
    logic [WIDTH+1:0]   rem_sh;
    logic [WIDTH+1:0]   trial;

    // The partial remainder never exceeds 2*root, so its top two bits are zero before each shift.
    always_comb begin
        rem_sh = {rem[WIDTH-1:0], rad[2*WIDTH-1 -: 2]};
        trial  = {root, 2'b01};
    end

    assign done = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            root <= '0;
            rem  <= '0;
        end else if (en) begin
            if (start && !busy) begin
                rad  <= radicand;
                cnt  <= '0;
                busy <= 1'b1;
                root <= '0;
                rem  <= '0;
            end else if (busy) begin
                rad <= rad << 2;
                cnt <= cnt + 1'b1;
                if (done)
                    busy <= 1'b0;
                if (rem_sh >= trial) begin
                    rem  <= rem_sh - trial;
                    root <= {root[WIDTH-2:0], 1'b1};
                end else begin
                    rem  <= rem_sh;
                    root <= {root[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/leg_solver.sv
// Computes b = floor(sqrt(c^2 - a^2)) with a shift-add multiplier and a serial square root.
// Optional remainder output rem_o is built with LEG_SOLVER_REM_EN.
module leg_solver
    import leg_solver_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    leg_solver_if.slave  bus
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    cnt;
    logic             err_q;
    logic             mul_last;
    logic             sqrt_start;
    logic             sqrt_busy;
    logic             sqrt_done;
    logic [WIDTH-1:0] sqrt_root;
`ifdef LEG_SOLVER_REM_EN
    logic [WIDTH+1:0] sqrt_rem;
`else
    logic [WIDTH+1:0] unused_rem;
`endif

    assign mul_last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        sqrt_start    = 1'b0;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.leg_o     = '0;
        bus.err_o     = 1'b0;
`ifdef LEG_SOLVER_REM_EN
        bus.rem_o     = '0;
`endif
        case (state)
            IDLE: if (en && bus.in_valid)
                      state_nxt = (bus.leg_i > bus.hyp_i) ? DONE : MUL;
            MUL:  if (en && mul_last)
                      state_nxt = SQRT;
            SQRT: begin
                sqrt_start = !sqrt_busy;
                if (en && sqrt_done)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.err_o = err_q;
                if (!err_q) begin
                    bus.leg_o = sqrt_root;
`ifdef LEG_SOLVER_REM_EN
                    bus.rem_o = PW'(sqrt_rem);
`endif
                end
                if (en && bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // c^2 - a^2 = (c - a)(c + a): one serial pass over the bits of the difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff  <= '0;
            sum   <= '0;
            prod  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    err_q <= (bus.leg_i > bus.hyp_i);
                    diff  <= bus.hyp_i - bus.leg_i;
                    sum   <= {1'b0, bus.hyp_i} + {1'b0, bus.leg_i};
                    prod  <= '0;
                    cnt   <= '0;
                end
                MUL: begin
                    if (diff[cnt])
                        prod <= prod + (PW'(sum) << cnt);
                    cnt <= mul_last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    isqrt_serial #(.WIDTH(WIDTH)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (sqrt_start),
        .radicand (prod),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root),
`ifdef LEG_SOLVER_REM_EN
        .rem      (sqrt_rem)
`else
        .rem      (unused_rem)
`endif
    );

endmodule

// File: doc/leg_solver.md
Name: leg_solver

Overview:
- Inverse of the team's magnitude block, which computes c = sqrt(a^2 + b^2).
- Given hypotenuse c and one leg a, returns the other leg b = floor(sqrt(c^2 - a^2)).
- Multi-cycle, area-lean: one shift-add multiplier and one bit-serial restoring square root, both iterative.
- Sits beside the magnitude block in the top-level datapath, with valid/ready handshakes on input and output.

Parameters:
- WIDTH, 8, operand and result width in bits; must be even and at least 4. Internal product/radicand width is 2*WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  clock enable; when low, all state holds and handshakes are not taken.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- hyp_i  input  WIDTH  hypotenuse c, unsigned.
- leg_i  input  WIDTH  known leg a, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- leg_o  output  WIDTH  unknown leg b, unsigned.
- err_o  output  1  set with the result when leg_i > hyp_i.
- rem_o  output  2*WIDTH  exactness remainder; present only with LEG_SOLVER_REM_EN.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; all registers clear.
  - in_ready = 1, out_valid = 0, leg_o = 0, err_o = 0, rem_o = 0.
- Reset mid-operation aborts the computation. No result is emitted.
- FSM states: IDLE, MUL, SQRT, DONE. All transitions are qualified by en = 1.
- IDLE:
  - in_ready = 1.
  - A handshake occurs on in_valid & in_ready & en; operands are latched.
  - If leg_i > hyp_i: leg_o = 0, err_o = 1, next state DONE.
  - Otherwise: diff = c - a (WIDTH bits), sum = c + a (WIDTH+1 bits), prod = 0, cnt = 0, next state MUL.
- MUL: WIDTH cycles.
  - Each cycle: if diff[cnt], prod += sum << cnt; then cnt++.
  - prod = c^2 - a^2, which is at most (2^WIDTH - 1)^2, so it fits in 2*WIDTH bits with no overflow.
  - On the last iteration: rem = 0, root = 0, cnt = 0, next state SQRT.
- SQRT: WIDTH cycles, restoring, MSB-first.
  - rem = (rem << 2) | top two bits of prod; prod <<= 2.
  - t = (root << 2) | 1.
  - If rem >= t: rem -= t, root = (root << 1) | 1. Otherwise root = root << 1.
  - After WIDTH iterations: leg_o = root, err_o = 0, next state DONE.
  - rem needs WIDTH+2 bits.
- DONE:
  - out_valid = 1, in_ready = 0.
  - leg_o, err_o and rem_o hold stable while out_ready is low.
  - On out_ready & en: out_valid drops the next cycle and the FSM returns to IDLE.
- No new input is accepted in the same cycle as output acceptance. There is no overlap and no pipelining.
- Latency:
  - Normal path: acceptance edge T, out_valid high from edge T + 2*WIDTH + 1 (17 cycles at WIDTH = 8).
  - Error path: out_valid high at T + 1.
- en low freezes the FSM, counters and datapath. Outputs hold.
- in_ready and out_valid are registered-state decodes, not combinational from inputs.

Optional Feature:
- Macro: LEG_SOLVER_REM_EN.
- Defined:
  - rem_o port exists and equals (c^2 - a^2) - leg_o^2, the final SQRT remainder zero-extended.
  - rem_o is 0 for exact results and 0 on error.
- Undefined:
  - rem_o port is absent; remainder only gets the internal width it needs.
  - All other behaviour is identical.

Decomposition:
- Shared package leg_solver_pkg holds:
  - FSM state enum (IDLE, MUL, SQRT, DONE).
  - localparams PROD_W = 2*WIDTH, CNT_W = clog2(WIDTH).
- One natural sub-module, isqrt_serial: the bit-serial restoring square-root engine.
  - Interface: start/busy/done, radicand in, root/rem out.
  - Reusable by the magnitude block for an exact floor-sqrt.
- The multiplier stays inline.

Test Plan:
- hyp=5, leg=3 -> leg_o=4, err_o=0, rem_o=0; out_valid exactly 17 cycles after acceptance.
- hyp=13, leg=5 -> 12; hyp=10, leg=3 -> leg_o=9, rem_o=10 (91 - 81).
- Boundaries:
  - hyp=255, leg=0 -> 255.
  - hyp=255, leg=255 -> 0.
  - hyp=0, leg=0 -> 0, err_o=0.
- hyp=3, leg=5 -> err_o=1, leg_o=0, out_valid at T+1; the next transaction computes correctly.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - in_valid pulses are ignored until out_ready.
  - en=0 for 3 cycles mid-MUL -> latency stretches by exactly 3 and the result is unchanged.
- Reset asserted mid-SQRT -> immediate IDLE, in_ready=1, out_valid=0, leg_o=0; the next operand pair (hyp=5, leg=4 -> 3) is correct.
